// File: rtl/bcd_pkg.sv
// Shared BCD digit type, modulus constants and per-digit limit helper
// for the up/down BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t MOD10 = 4'd10;
    localparam bcd_digit_t MOD6  = 4'd6;

    function automatic bcd_digit_t digit_max(input logic mod6_sel);
        return mod6_sel ? (MOD6 - 4'd1) : (MOD10 - 4'd1);
    endfunction

    function automatic bcd_digit_t digit_mod(input logic mod6_sel);
        return mod6_sel ? MOD6 : MOD10;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit adder/subtractor: adds or subtracts an addend
// modulo 6 or 10 and reports the carry/borrow into the next digit.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       mod6_sel_i,
    input  bcd_digit_t addend_i,
    input  logic       down_i,
    output bcd_digit_t digit_o,
    output logic       carry_o
);

    logic [4:0] mod_w;
    logic [4:0] dig_w;
    logic [4:0] add_w;
    logic [4:0] res_w;

    assign mod_w = {1'b0, digit_mod(mod6_sel_i)};
    assign dig_w = {1'b0, digit_i};
    assign add_w = {1'b0, addend_i};

    // addend never reaches the modulus, so one correction step is enough
    always_comb begin
        res_w   = dig_w;
        carry_o = 1'b0;
        if (!down_i) begin
            res_w = dig_w + add_w;
            if (res_w >= mod_w) begin
                res_w   = res_w - mod_w;
                carry_o = 1'b1;
            end
        end else if (dig_w < add_w) begin
            res_w   = dig_w + mod_w - add_w;
            carry_o = 1'b1;
        end else begin
            res_w = dig_w - add_w;
        end
    end

    assign digit_o = res_w[3:0];

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with per-digit modulo 6/10, load with
// digit range checking, and wrap or saturate behaviour at the boundaries.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int                    NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS-1:0] MOD_PATTERN = 4'b1010,
    parameter int                    STEP        = 1,
    parameter bit                    WRAP_MODE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic                    load_err,
    output logic                    at_zero,
    output logic                    at_max
);

    localparam int W = 4 * NUM_DIGITS;
    localparam bcd_digit_t STEP_D = bcd_digit_t'(STEP);

    logic [W-1:0]          count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic                  load_err_q, load_err_d;

    logic [W-1:0]          max_val;
    logic [W-1:0]          load_clean;
    logic                  load_bad;
    logic [W-1:0]          chain_val;
    logic [NUM_DIGITS-1:0] chain_carry;
    logic                  do_count;

    function automatic logic [W-1:0] sat_select(input logic [W-1:0] wrapped,
                                                input logic         edge_hit,
                                                input logic         dir_down,
                                                input logic [W-1:0] top_val);
        if (WRAP_MODE || !edge_hit)
            return wrapped;
        return dir_down ? '0 : top_val;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_t addend;
            if (g == 0) begin : g_lsd
                assign addend = STEP_D;
            end else begin : g_upper
                assign addend = {3'b000, chain_carry[g-1]};
            end

            bcd_digit_cell u_cell (
                .digit_i    (count_q[4*g +: 4]),
                .mod6_sel_i (MOD_PATTERN[g]),
                .addend_i   (addend),
                .down_i     (down),
                .digit_o    (chain_val[4*g +: 4]),
                .carry_o    (chain_carry[g])
            );
        end
    endgenerate

    always_comb begin
        max_val    = '0;
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            max_val[4*i +: 4] = digit_max(MOD_PATTERN[i]);
            if (load_val[4*i +: 4] > digit_max(MOD_PATTERN[i]))
                load_bad = 1'b1;
            else
                load_clean[4*i +: 4] = load_val[4*i +: 4];
        end
    end

    assign do_count = en && (up ^ down);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d    = load_clean;
            load_err_d = load_bad;
        end else if (do_count) begin
            count_d = sat_select(chain_val, chain_carry[NUM_DIGITS-1], down, max_val);
            wrap_d  = chain_carry[NUM_DIGITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign at_zero  = (count_q == '0);
    assign at_max   = (count_q == max_val);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: four parameterisations share one
// stimulus stream and are checked against hand-computed values.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst_n, en, up, down, clear, load;
    logic [15:0] load_val;

    logic [15:0] c_w,  c_s,  c_3,  c_3s;
    logic        wr_w, wr_s, wr_3, wr_3s;
    logic        le_w, le_s, le_3, le_3s;
    logic        az_w, az_s, az_3, az_3s;
    logic        am_w, am_s, am_3, am_3s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.NUM_DIGITS(4), .MOD_PATTERN(4'b1010), .STEP(1), .WRAP_MODE(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .clear(clear), .load(load),
        .load_val(load_val), .count(c_w), .wrap(wr_w), .load_err(le_w), .at_zero(az_w), .at_max(am_w));

    bcd_updown_counter #(.NUM_DIGITS(4), .MOD_PATTERN(4'b1010), .STEP(1), .WRAP_MODE(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .clear(clear), .load(load),
        .load_val(load_val), .count(c_s), .wrap(wr_s), .load_err(le_s), .at_zero(az_s), .at_max(am_s));

    bcd_updown_counter #(.NUM_DIGITS(4), .MOD_PATTERN(4'b1010), .STEP(3), .WRAP_MODE(1'b1)) dut_3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .clear(clear), .load(load),
        .load_val(load_val), .count(c_3), .wrap(wr_3), .load_err(le_3), .at_zero(az_3), .at_max(am_3));

    bcd_updown_counter #(.NUM_DIGITS(4), .MOD_PATTERN(4'b1010), .STEP(3), .WRAP_MODE(1'b0)) dut_3s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .clear(clear), .load(load),
        .load_val(load_val), .count(c_3s), .wrap(wr_3s), .load_err(le_3s), .at_zero(az_3s), .at_max(am_3s));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic d,
                         input logic c, input logic l, input logic [15:0] v);
        rst_n = r; en = e; up = u; down = d; clear = c; load = l; load_val = v;
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        tick();
        chk("rst_count", c_w, 16'h0000);
        chk("rst_wrap", {15'd0, wr_w}, 16'd0);
        chk("rst_lerr", {15'd0, le_w}, 16'd0);
        chk("rst_at_zero", {15'd0, az_w}, 16'd1);
        chk("rst_at_max", {15'd0, am_w}, 16'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5959);
        tick();
        chk("load_5959", c_w, 16'h5959);
        chk("at_max_5959", {15'd0, am_w}, 16'd1);
        chk("lerr_valid_load", {15'd0, le_w}, 16'd0);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("wrap_up_count", c_w, 16'h0000);
        chk("wrap_up_pulse", {15'd0, wr_w}, 16'd1);
        chk("sat_up_count", c_s, 16'h5959);
        chk("sat_up_pulse", {15'd0, wr_s}, 16'd1);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("en_low_hold", c_w, 16'h0000);
        chk("wrap_one_cycle", {15'd0, wr_w}, 16'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        chk("clear_sat", c_s, 16'h0000);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("wrap_down_count", c_w, 16'h5959);
        chk("wrap_down_pulse", {15'd0, wr_w}, 16'd1);
        chk("sat_down_count", c_s, 16'h0000);
        chk("sat_down_pulse", {15'd0, wr_s}, 16'd1);
        chk("sat_down_at_zero", {15'd0, az_s}, 16'd1);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0959);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("ripple_1000", c_w, 16'h1000);
        chk("ripple_no_wrap", {15'd0, wr_w}, 16'd0);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("updown_hold", c_w, 16'h1000);
        chk("updown_no_wrap", {15'd0, wr_w}, 16'd0);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("borrow_0959", c_w, 16'h0959);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0058);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("step3_0101", c_3, 16'h0101);
        chk("step3_no_wrap", {15'd0, wr_3}, 16'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7A12);
        tick();
        chk("bad_load_count", c_w, 16'h0012);
        chk("bad_load_err", {15'd0, le_w}, 16'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("lerr_one_cycle", {15'd0, le_w}, 16'd0);
        chk("hold_after_bad", c_w, 16'h0012);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        chk("clear_over_load", c_w, 16'h0000);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5959);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        tick();
        chk("rst_over_load", c_w, 16'h0000);
        chk("rst_over_load_wrap", {15'd0, wr_w}, 16'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5958);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("step3_sat_count", c_3s, 16'h5959);
        chk("step3_sat_wrap", {15'd0, wr_3s}, 16'd1);
        chk("step3_sat_at_max", {15'd0, am_3s}, 16'd1);
        chk("step3_wrap_count", c_3, 16'h0001);
        chk("step3_wrap_pulse", {15'd0, wr_3}, 16'd1);
        tick();
        chk("sat_hold_max", c_3s, 16'h5959);
        chk("sat_hold_wrap", {15'd0, wr_3s}, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits, range 1..8.
REQ-002 SHALL have parameter MOD_PATTERN, default 4'b1010, NUM_DIGITS bits: bit i=1 makes digit i modulo 6 (0..5), bit i=0 makes it modulo 10 (0..9).
REQ-003 SHALL have parameter STEP, default 1: increment/decrement applied to digit 0, range 1..(digit-0 modulus - 1).
REQ-004 SHALL have parameter WRAP_MODE, default 1: 1 = wrap at the boundaries, 0 = saturate at the boundaries.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  count enable; counting occurs only when high.
REQ-008 up  input  1  count up by STEP.
REQ-009 down  input  1  count down by STEP.
REQ-010 clear  input  1  synchronous clear to zero.
REQ-011 load  input  1  load load_val.
REQ-012 load_val  input  4*NUM_DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
REQ-013 count  output  4*NUM_DIGITS  registered BCD count; digit 0 is least significant.
REQ-014 wrap  output  1  one-cycle pulse when the count wrapped (WRAP_MODE=1) or saturated (WRAP_MODE=0).
REQ-015 load_err  output  1  one-cycle pulse when a loaded digit was out of range.
REQ-016 at_zero  output  1  high while count is all zeros.
REQ-017 at_max  output  1  high while every digit equals its modulus-1.

Function
REQ-018 Per-cycle priority SHALL be: rst_n low, then clear, then load, then count (en high with exactly one of up/down high), then hold.
REQ-019 up and down both high, or en low, SHALL hold the count with no wrap pulse.
REQ-020 Count up SHALL add STEP to digit 0; a digit result >= its modulus SHALL subtract the modulus and carry 1 into the next digit; carries ripple through all digits within one cycle.
REQ-021 Count down SHALL subtract STEP from digit 0; a negative digit result SHALL add the modulus and borrow 1 from the next digit.
REQ-022 Carry out of, or borrow from, the top digit with WRAP_MODE=1 SHALL discard the carry/borrow, keep the wrapped digits, and pulse wrap.
REQ-023 Overflow with WRAP_MODE=0 SHALL set count to the maximum value and pulse wrap; underflow SHALL set count to zero and pulse wrap.
REQ-024 Counting up from the maximum value with WRAP_MODE=0 SHALL hold the maximum value and pulse wrap; counting down from zero SHALL hold zero and pulse wrap.
REQ-025 Load SHALL replace each digit with its load_val digit; any digit >= its modulus SHALL be loaded as 0, with load_err pulsed once for that load.
REQ-026 Latency: count, wrap, and load_err SHALL reflect the inputs sampled at edge N immediately after edge N; at_zero and at_max SHALL be derived from the count register, with no extra latency.
REQ-027 wrap and load_err SHALL be low in every cycle where their condition does not occur.

Reset
REQ-028 rst_n low at a rising edge SHALL force count=0, wrap=0, load_err=0, regardless of other inputs, including mid-count and coincident with load.
REQ-029 After reset, at_zero=1 and at_max=0 (NUM_DIGITS>=1).

Structure
REQ-030 Shared package bcd_pkg SHALL hold the 4-bit BCD digit typedef, the MOD10/MOD6 constants, and a function returning a digit's maximum value from its pattern bit.
REQ-031 A single sub-module, bcd_digit_cell, SHALL be used, instantiated NUM_DIGITS times. It is combinational and takes the digit value, modulus select, addend (STEP or carry), and direction; it returns the next digit value and the carry/borrow out.
REQ-032 The digit register and the wrap/saturate selection SHALL live in the top module only.

Verification (NUM_DIGITS=4, MOD_PATTERN=4'b1010, STEP=1 unless noted)
REQ-033 Load 0x5959, en=1, up=1 for one cycle (WRAP_MODE=1) -> count=0x0000, wrap=1 for one cycle.
REQ-034 Count 0x0000, down for one cycle (WRAP_MODE=1) -> count=0x5959, wrap=1; with WRAP_MODE=0 -> count=0x0000, wrap=1.
REQ-035 Load 0x0959, up for one cycle -> 0x1000 in one cycle with no wrap; STEP=3 from 0x0058 up -> 0x0101.
REQ-036 load_val=0x7A12 -> count=0x0012, load_err=1 for one cycle.
REQ-037 Same cycle: up=down=1 -> count holds; clear+load -> 0x0000; rst_n=0+load -> 0x0000, wrap=0.
REQ-038 WRAP_MODE=0, STEP=3, count 0x5958, up for one cycle -> count=0x5959, wrap=1, at_max=1.
